// File: rtl/tuner_phy_pkg.sv
// tuner_phy_pkg: shared types for the tuner PHY access arbiter
package tuner_phy_pkg;
  typedef enum logic [1:0] {
    ARB_CTRL_INIT   = 2'd0,
    ARB_CTRL_TUNE   = 2'd1,
    ARB_CTRL_SYNC   = 2'd2,
    ARB_CTRL_COMMIT = 2'd3
  } tuner_phy_ctrl_arb_state_e;
  typedef enum logic {
    CH_SEARCH = 1'b0,
    CH_LOCK   = 1'b1
  } tuner_ctrl_ch_e;
  typedef enum logic {
    ERROR_NONE    = 1'b0,
    ERROR_TIMEOUT = 1'b1
  } tuner_phy_error_state_e;
endpackage

// File: rtl/tuner_phy_rr_arb2.sv
// tuner_phy_rr_arb2: two-way round-robin selector remembering the last grant
module tuner_phy_rr_arb2
  import tuner_phy_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_i,
  input  logic           load_i,
  output tuner_ctrl_ch_e sel_o
);
  tuner_ctrl_ch_e last_q;
  // a lone requester wins; on a tie the channel not granted last time wins
  always_comb sel_o = (&req_i) ? ((last_q == CH_LOCK) ? CH_SEARCH : CH_LOCK)
                               : (req_i[1] ? CH_LOCK : CH_SEARCH);
  // last grant starts at lock so search wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= CH_LOCK;
    else if (load_i) last_q <= sel_o;
endmodule

// File: rtl/tuner_phy_ctrl_arb.sv
// tuner_phy_ctrl_arb: grants tuner DAC/ADC access to search or lock controller
module tuner_phy_ctrl_arb
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH      = 8,
  parameter int ADC_WIDTH      = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           ch_req,
  input  logic [DAC_WIDTH-1:0] ch_code_search,
  input  logic [DAC_WIDTH-1:0] ch_code_lock,
  output logic [1:0]           ch_gnt,
  output logic [1:0]           ch_pwr_valid,
  output logic [ADC_WIDTH-1:0] ch_pwr,
  output logic [1:0]           ch_err,
  output logic [DAC_WIDTH-1:0] dac_code,
  output logic                 dac_valid,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic                 busy,
  output logic [1:0]           arb_state
);
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  tuner_phy_ctrl_arb_state_e state_q, state_d;
  tuner_ctrl_ch_e            ch_q, ch_d, sel;
  tuner_phy_error_state_e    err_q, err_d;
  logic [SW-1:0]             settle_q, settle_d;
  logic [TW-1:0]             to_q, to_d;
  logic [DAC_WIDTH-1:0]      dac_code_q, dac_code_d;
  logic [ADC_WIDTH-1:0]      pwr_q, pwr_d;
  logic                      load;
  logic [1:0]                ch_oh;

  tuner_phy_rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (ch_req),
    .load_i (load),
    .sel_o  (sel)
  );

  // next state: grant, settle, sample-or-timeout, commit
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    err_d      = err_q;
    settle_d   = settle_q;
    to_d       = to_q;
    dac_code_d = dac_code_q;
    pwr_d      = pwr_q;
    load       = 1'b0;
    case (state_q)
      ARB_CTRL_INIT: if (|ch_req) begin
        load       = 1'b1;
        ch_d       = sel;
        dac_code_d = (sel == CH_LOCK) ? ch_code_lock : ch_code_search;
        state_d    = ARB_CTRL_TUNE;
      end
      ARB_CTRL_TUNE: begin
        settle_d = SW'(SETTLE_CYCLES);
        state_d  = ARB_CTRL_SYNC;
      end
      ARB_CTRL_SYNC: if (settle_q != '0) settle_d = settle_q - SW'(1);
      else if (adc_valid) begin
        pwr_d   = adc_data;
        state_d = ARB_CTRL_COMMIT;
      end else begin
        to_d = to_q + TW'(1);
        if (to_d == TW'(TIMEOUT_CYCLES)) begin
          pwr_d   = '0;
          err_d   = ERROR_TIMEOUT;
          state_d = ARB_CTRL_COMMIT;
        end
      end
      default: begin
        settle_d = '0;
        to_d     = '0;
        err_d    = ERROR_NONE;
        state_d  = ARB_CTRL_INIT;
      end
    endcase
  end

  // state and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ARB_CTRL_INIT;
      ch_q       <= CH_SEARCH;
      err_q      <= ERROR_NONE;
      settle_q   <= '0;
      to_q       <= '0;
      dac_code_q <= '0;
      pwr_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      err_q      <= err_d;
      settle_q   <= settle_d;
      to_q       <= to_d;
      dac_code_q <= dac_code_d;
      pwr_q      <= pwr_d;
    end

  assign ch_oh        = (ch_q == CH_LOCK) ? 2'b10 : 2'b01;
  assign ch_gnt       = (state_q == ARB_CTRL_TUNE) ? ch_oh : 2'b00;
  assign dac_valid    = state_q == ARB_CTRL_TUNE;
  assign ch_pwr_valid = (state_q == ARB_CTRL_COMMIT) ? ch_oh : 2'b00;
  assign ch_err       = (state_q == ARB_CTRL_COMMIT && err_q == ERROR_TIMEOUT) ? ch_oh : 2'b00;
  assign ch_pwr       = pwr_q;
  assign dac_code     = dac_code_q;
  assign busy         = state_q != ARB_CTRL_INIT;
  assign arb_state    = state_q;

  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ch_gnt) && $onehot0(ch_pwr_valid) && $onehot0(ch_err));
endmodule

// File: tb/tb_tuner_phy_ctrl_arb.sv
// tb_tuner_phy_ctrl_arb: table-driven and randomized checks of the tuner arbiter
module tb_tuner_phy_ctrl_arb;
  localparam int S = 4, T = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] ch_req = '0;
  logic [7:0] ch_code_search = '0, ch_code_lock = '0, adc_data = '0;
  logic adc_valid = 1'b0;
  logic [1:0] ch_gnt, ch_pwr_valid, ch_err, arb_state;
  logic [7:0] ch_pwr, dac_code;
  logic dac_valid, busy;
  logic [1:0] b_req = '0;
  logic [7:0] b_cs = '0, b_cl = '0, b_adc_data = '0;
  logic b_adc_valid = 1'b0;
  logic [1:0] b_gnt, b_pv, b_err, b_state;
  logic [7:0] b_pwr, b_dac;
  logic b_dv, b_busy;

  tuner_phy_ctrl_arb #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_code_search(ch_code_search),
    .ch_code_lock(ch_code_lock), .ch_gnt(ch_gnt), .ch_pwr_valid(ch_pwr_valid),
    .ch_pwr(ch_pwr), .ch_err(ch_err), .dac_code(dac_code), .dac_valid(dac_valid),
    .adc_valid(adc_valid), .adc_data(adc_data), .busy(busy), .arb_state(arb_state));

  tuner_phy_ctrl_arb #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .ch_req(b_req), .ch_code_search(b_cs),
    .ch_code_lock(b_cl), .ch_gnt(b_gnt), .ch_pwr_valid(b_pv),
    .ch_pwr(b_pwr), .ch_err(b_err), .dac_code(b_dac), .dac_valid(b_dv),
    .adc_valid(b_adc_valid), .adc_data(b_adc_data), .busy(b_busy), .arb_state(b_state));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] cs, cl;
    bit         stale;
    logic [7:0] sdat;
    int         vs;
    logic [7:0] dat;
    int         ech;
    logic [7:0] epwr;
    bit         eerr;
    int         elat;
  } vec_t;

  vec_t tbl[10];
  int n_cmp = 0, n_fail = 0;
  bit av[256];
  logic [7:0] ad[256];

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // adc stimulus indexed by cycles after the grant cycle: settle window then eligible window
  task automatic fill_adc(input bit stale, input logic [7:0] sdat, input int vs, input logic [7:0] dat);
    for (int j = 0; j < 256; j++) begin
      av[j] = (j == 0) ? 1'b0 : (j <= S) ? stale : (vs >= 0 && (j - S - 1) >= vs);
      ad[j] = (j <= S) ? sdat : dat;
    end
  endtask

  // reference: the first valid sample inside the eligible window wins, else timeout
  task automatic predict(output logic [7:0] pwr, output bit err, output int lat);
    pwr = 8'h00;
    err = 1'b1;
    lat = S + T + 2;
    for (int e = T - 1; e >= 0; e--)
      if (av[S + 1 + e]) begin
        pwr = ad[S + 1 + e];
        err = 1'b0;
        lat = S + 3 + e;
      end
  endtask

  task automatic run_txn(input string nm, input logic [1:0] req, input logic [7:0] cs, input logic [7:0] cl,
                         input int ech, input logic [7:0] epwr, input bit eerr, input int elat);
    int lat;
    bit done;
    logic [1:0] oh;
    logic [7:0] code;
    oh = (ech == 1) ? 2'b10 : 2'b01;
    code = (ech == 1) ? cl : cs;
    chk(nm, "idle", {30'd0, arb_state}, 32'd0);
    ch_req = req;
    ch_code_search = cs;
    ch_code_lock = cl;
    adc_valid = 1'b0;
    step;
    lat = 1;
    chk(nm, "gnt", {30'd0, ch_gnt}, {30'd0, oh});
    chk(nm, "dac_valid", {31'd0, dac_valid}, 32'd1);
    chk(nm, "dac_code", {24'd0, dac_code}, {24'd0, code});
    ch_req = 2'b00;
    adc_valid = av[0];
    adc_data = ad[0];
    done = 1'b0;
    while (!done && lat < 200) begin
      step;
      lat++;
      if (ch_pwr_valid != 2'b00) done = 1'b1;
      else begin
        adc_valid = av[lat - 1];
        adc_data = ad[lat - 1];
      end
    end
    chk(nm, "latency", lat, elat);
    chk(nm, "pwr_valid", {30'd0, ch_pwr_valid}, {30'd0, oh});
    chk(nm, "pwr", {24'd0, ch_pwr}, {24'd0, epwr});
    chk(nm, "err", {30'd0, ch_err}, eerr ? {30'd0, oh} : 32'd0);
    chk(nm, "dac_hold", {24'd0, dac_code}, {24'd0, code});
    adc_valid = 1'b0;
    step;
    chk(nm, "busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_b(input string nm, input logic [1:0] req, input bit v, input logic [7:0] dat,
                       input logic [7:0] epwr, input logic [1:0] eerr, input int elat);
    int lat;
    b_req = req;
    b_cs = 8'h1E;
    b_cl = 8'hE1;
    b_adc_valid = v;
    b_adc_data = dat;
    step;
    lat = 1;
    chk(nm, "gnt", {30'd0, b_gnt}, {30'd0, req});
    chk(nm, "dac_code", {24'd0, b_dac}, req[1] ? 32'hE1 : 32'h1E);
    b_req = 2'b00;
    while (b_pv == 2'b00 && lat < 50) begin
      step;
      lat++;
    end
    chk(nm, "latency", lat, elat);
    chk(nm, "pwr_valid", {30'd0, b_pv}, {30'd0, req});
    chk(nm, "pwr", {24'd0, b_pwr}, {24'd0, epwr});
    chk(nm, "err", {30'd0, b_err}, {30'd0, eerr});
    b_adc_valid = 1'b0;
    step;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last, ech, elat;
    logic [1:0] rq;
    logic [7:0] cs, cl, epwr;
    bit eerr;
    tbl[0] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h00, 0,  8'h44, 0, 8'h44, 1'b0, 7};
    tbl[1] = '{2'b11, 8'h11, 8'h22, 1'b0, 8'h00, 0,  8'h55, 1, 8'h55, 1'b0, 7};
    tbl[2] = '{2'b11, 8'h13, 8'h24, 1'b1, 8'h66, 0,  8'h66, 0, 8'h66, 1'b0, 7};
    tbl[3] = '{2'b11, 8'h13, 8'h24, 1'b1, 8'h67, 2,  8'h68, 1, 8'h68, 1'b0, 9};
    tbl[4] = '{2'b01, 8'h5A, 8'h00, 1'b1, 8'h33, 0,  8'h33, 0, 8'h33, 1'b0, 7};
    tbl[5] = '{2'b10, 8'h00, 8'h77, 1'b1, 8'hFF, 0,  8'h10, 1, 8'h10, 1'b0, 7};
    tbl[6] = '{2'b01, 8'h81, 8'h00, 1'b0, 8'h00, 5,  8'h9C, 0, 8'h9C, 1'b0, 12};
    tbl[7] = '{2'b10, 8'h00, 8'hE1, 1'b0, 8'h00, -1, 8'h00, 1, 8'h00, 1'b1, 70};
    tbl[8] = '{2'b11, 8'hA0, 8'hB0, 1'b0, 8'h00, 63, 8'hA5, 0, 8'hA5, 1'b0, 70};
    tbl[9] = '{2'b11, 8'hA0, 8'hB0, 1'b1, 8'hFF, -1, 8'h00, 1, 8'h00, 1'b1, 70};
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "state", {30'd0, arb_state}, 32'd0);
    chk("reset", "busy", {31'd0, busy}, 32'd0);
    chk("reset", "dac_code", {24'd0, dac_code}, 32'd0);
    chk("reset", "pwr", {24'd0, ch_pwr}, 32'd0);
    chk("reset", "pulses", {26'd0, ch_gnt, ch_pwr_valid, ch_err}, {31'd0, dac_valid});
    rst_n = 1'b1;
    step;
    for (int i = 0; i < 10; i++) begin
      fill_adc(tbl[i].stale, tbl[i].sdat, tbl[i].vs, tbl[i].dat);
      run_txn($sformatf("tbl%0d", i), tbl[i].req, tbl[i].cs, tbl[i].cl,
              tbl[i].ech, tbl[i].epwr, tbl[i].eerr, tbl[i].elat);
    end
    last = 1;
    for (int k = 0; k < 20; k++) begin
      rq = 2'($urandom_range(1, 3));
      cs = 8'($urandom);
      cl = 8'($urandom);
      ech = (rq == 2'b11) ? 1 - last : (rq == 2'b10) ? 1 : 0;
      last = ech;
      for (int j = 0; j < 256; j++) begin
        av[j] = (j > 0) && (k % 5 != 4 || j <= S) && ($urandom_range(0, 5) == 0);
        ad[j] = 8'($urandom);
      end
      predict(epwr, eerr, elat);
      run_txn($sformatf("rnd%0d", k), rq, cs, cl, ech, epwr, eerr, elat);
    end
    ch_req = 2'b01;
    ch_code_search = 8'hC3;
    step;
    ch_req = 2'b00;
    step;
    step;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sync", "state", {30'd0, arb_state}, 32'd0);
    chk("rst_sync", "busy", {31'd0, busy}, 32'd0);
    chk("rst_sync", "dac_code", {24'd0, dac_code}, 32'd0);
    chk("rst_sync", "pwr", {24'd0, ch_pwr}, 32'd0);
    adc_valid = 1'b1;
    adc_data = 8'hEE;
    repeat (3) begin
      step;
      chk("rst_sync", "no_pwr_valid", {30'd0, ch_pwr_valid}, 32'd0);
    end
    rst_n = 1'b1;
    adc_valid = 1'b0;
    repeat (8) begin
      step;
      chk("rst_after", "no_pwr_valid", {30'd0, ch_pwr_valid}, 32'd0);
    end
    fill_adc(1'b1, 8'h21, 0, 8'h21);
    run_txn("post_rst", 2'b11, 8'h31, 8'h32, 0, 8'h21, 1'b0, 7);
    run_b("s0_valid", 2'b10, 1'b1, 8'h7E, 8'h7E, 2'b00, 3);
    run_b("s0_timeout", 2'b01, 1'b0, 8'h55, 8'h00, 2'b01, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tuner_phy_ctrl_arb.md
Name: tuner_phy_ctrl_arb

Overview:
- Shared tuner-access arbiter between the search and lock controllers and the tuner DAC / power ADC.
- Grants one controller channel (CH_SEARCH or CH_LOCK) at a time.
- Drives the granted tuner code to the DAC and waits a settle interval.
- Captures one ADC power sample and returns it to the requesting channel.
- Sits directly downstream of both controllers and upstream of the analog front-end.

Parameters:
- DAC_WIDTH, 8, tuner code width.
- ADC_WIDTH, 8, power sample width.
- SETTLE_CYCLES, 4, cycles ignored after each DAC update; 0 is legal.
- TIMEOUT_CYCLES, 64, maximum number of eligible cycles spent waiting for adc_valid; must be ≥1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_req  in  2  request per channel, indexed by tuner_ctrl_ch_e.
- ch_code_search  in  DAC_WIDTH  search channel code.
- ch_code_lock  in  DAC_WIDTH  lock channel code.
- ch_gnt  out  2  one-cycle grant pulse.
- ch_pwr_valid  out  2  one-cycle result pulse.
- ch_pwr  out  ADC_WIDTH  result sample; shared, qualified by ch_pwr_valid.
- ch_err  out  2  timeout pulse, coincident with ch_pwr_valid.
- dac_code  out  DAC_WIDTH  tuner code (registered, held).
- dac_valid  out  1  one-cycle DAC update strobe.
- adc_valid  in  1  power sample strobe.
- adc_data  in  ADC_WIDTH  power sample.
- busy  out  1  high when state != ARB_CTRL_INIT.
- arb_state  out  2  current tuner_phy_ctrl_arb_state_e.

Behaviour:
- Reset values:
  - state = ARB_CTRL_INIT.
  - All pulse outputs = 0; dac_code = 0; ch_pwr = 0; busy = 0.
  - last_grant = CH_LOCK, so search wins the first tie.
- Reset is asynchronous. Reset mid-transaction aborts it: no ch_pwr_valid is ever issued for the aborted request.
- ARB_CTRL_INIT:
  - If any ch_req is high, select a channel. A single requester wins. If both request, the winner is the channel != last_grant.
  - At the clock edge: latch the selected channel and its code into dac_code, update last_grant, go to TUNE.
  - With no request, stay.
- ARB_CTRL_TUNE (exactly 1 cycle):
  - ch_gnt[ch] = 1 and dac_valid = 1.
  - Load the settle counter with SETTLE_CYCLES; go to SYNC.
- ARB_CTRL_SYNC:
  - Settle phase: the first SETTLE_CYCLES cycles decrement the settle counter. adc_valid is ignored during this phase (stale sample).
  - Sample phase: once the counter is 0, each cycle is eligible. On an eligible cycle with adc_valid = 1, capture adc_data and go to COMMIT.
  - Timeout: the timeout counter counts eligible cycles without adc_valid. Reaching TIMEOUT_CYCLES sets the timeout flag and goes to COMMIT.
- ARB_CTRL_COMMIT (exactly 1 cycle):
  - ch_pwr_valid[ch] = 1; ch_pwr = the captured sample, or 0 on timeout.
  - ch_err[ch] = timeout flag.
  - Clear both counters and the flag; go to INIT.
- Latency: with adc_valid held high, a request first seen in INIT at cycle t gives:
  - ch_gnt at t+1;
  - ch_pwr_valid at t+SETTLE_CYCLES+3.
- Requester rules:
  - Requesters hold ch_req and the code until ch_gnt and drop ch_req after it.
  - ch_req seen outside INIT is not lost. It is evaluated on return to INIT, so back-to-back service has one idle INIT cycle.
- dac_code holds its value between transactions and is only updated at grant.
- No output depends combinationally on any input.
- Counter widths: $clog2(SETTLE_CYCLES+1) for the settle counter and $clog2(TIMEOUT_CYCLES+1) for the timeout counter; no wrap-around within legal ranges.
- Only one bit of ch_gnt, ch_pwr_valid and ch_err may ever be set at once. Assert this.

Decomposition:
- Shared package tuner_phy_pkg supplies tuner_phy_ctrl_arb_state_e, tuner_ctrl_ch_e and tuner_phy_error_state_e (ERROR_TIMEOUT is used for debug/status mapping). No new package types are required.
- One natural sub-module: tuner_phy_rr_arb2, the 2-way round-robin selector holding last_grant with a load enable. All other logic stays in the top module.

Test Plan:
- Single search request, code 0x5A, SETTLE_CYCLES=4, adc_valid high with adc_data 0x33, request at cycle 0 -> ch_gnt[0] at 1; dac_code=0x5A with dac_valid at 1; ch_pwr_valid[0] at 7 with ch_pwr=0x33; ch_err=0.
- Both channels request at reset exit -> search granted first, then lock; repeated with both held, grants alternate S, L, S, L.
- adc_valid pulsed with 0xFF during the settle phase, then 0x10 on the first eligible cycle -> ch_pwr=0x10 (stale sample rejected).
- adc_valid never asserted, TIMEOUT_CYCLES=64 -> ch_pwr_valid and ch_err on the same channel 64 eligible cycles after settle ends; ch_pwr=0; returns to INIT.
- rst_n asserted during SYNC -> immediate reset values, no ch_pwr_valid; a fresh request after release is served normally.
- SETTLE_CYCLES=0, adc_valid high -> ch_pwr_valid at t+3.
